// File: rtl/npu_result_drain.sv
// npu_result_drain
//   Drains the PE result-cache banks onto one shared output stream after the
//   NPU save phase. On an accepted start it visits every enabled bank in
//   ascending index order: one SOP cycle that pulses rd_sop to the bank, then
//   zero-latency forwarding of that bank's words until it flags its last word.
//   The job ends with a one-cycle done pulse; word_cnt holds the word total.
//
// Ports
//   clk, rst          clock, synchronous active-high reset
//   start             one-cycle job start (ignored while busy -> start_drop)
//   bank_en           banks to drain, sampled on an accepted start
//   rd_sop            per-bank one-cycle read-start pulse (registered)
//   bank_valid/data/last, bank_ready   per-bank pop interface
//   m_valid/data/bank_id/last, m_ready output stream
//   busy, done, start_drop, word_cnt   status
module npu_result_drain #(
  parameter int NUM_BANK = 8,
  parameter int DATA_W   = 32,
  parameter int ID_W     = 3,
  parameter int CNT_W    = 16
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       start,
  input  logic [NUM_BANK-1:0]        bank_en,
  output logic [NUM_BANK-1:0]        rd_sop,
  input  logic [NUM_BANK-1:0]        bank_valid,
  input  logic [NUM_BANK*DATA_W-1:0] bank_data,
  input  logic [NUM_BANK-1:0]        bank_last,
  output logic [NUM_BANK-1:0]        bank_ready,
  output logic                       m_valid,
  output logic [DATA_W-1:0]          m_data,
  output logic [ID_W-1:0]            m_bank_id,
  output logic                       m_last,
  input  logic                       m_ready,
  output logic                       busy,
  output logic                       done,
  output logic                       start_drop,
  output logic [CNT_W-1:0]           word_cnt
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_SOP  = 2'd1;
  localparam logic [1:0] S_XFER = 2'd2;
  localparam logic [1:0] S_DONE = 2'd3;

  function automatic logic [ID_W-1:0] lowest_idx(input logic [NUM_BANK-1:0] v);
    logic [ID_W-1:0] r;
    r = '0;
    for (int i = NUM_BANK - 1; i >= 0; i--) begin
      if (v[i]) r = ID_W'(i);
    end
    return r;
  endfunction

  function automatic logic [NUM_BANK-1:0] onehot(input logic [ID_W-1:0] idx);
    return NUM_BANK'(1) << idx;
  endfunction

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
    return (&c) ? c : c + 1'b1;
  endfunction

  logic [1:0]          state_q, state_d;
  logic [NUM_BANK-1:0] en_q, en_d;
  logic [ID_W-1:0]     cur_q, cur_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [NUM_BANK-1:0] rd_sop_q, rd_sop_d;
  logic                done_q, done_d;
  logic                drop_q, drop_d;

  logic [DATA_W-1:0]   bank_word [NUM_BANK];
  logic [NUM_BANK-1:0] cur_oh, en_rest;
  logic                in_xfer, sel_valid, sel_last, fire;

  for (genvar g = 0; g < NUM_BANK; g++) begin : g_slice
    assign bank_word[g] = bank_data[g*DATA_W +: DATA_W];
  end

  assign cur_oh    = onehot(cur_q);
  // Banks still owed a visit once the current one finishes.
  assign en_rest   = en_q & ~cur_oh;
  assign in_xfer   = (state_q == S_XFER);
  assign sel_valid = bank_valid[cur_q];
  assign sel_last  = bank_last[cur_q];

  assign m_valid    = in_xfer & sel_valid;
  assign m_data     = in_xfer ? bank_word[cur_q] : '0;
  assign m_bank_id  = cur_q;
  assign m_last     = in_xfer & sel_valid & sel_last & ~(|en_rest);
  assign bank_ready = in_xfer ? (cur_oh & {NUM_BANK{m_ready}}) : '0;
  assign fire       = m_valid & m_ready;

  always_comb begin
    state_d = state_q;
    en_d    = en_q;
    cur_d   = cur_q;
    cnt_d   = cnt_q;
    drop_d  = start & (state_q != S_IDLE);
    case (state_q)
      S_IDLE: begin
        if (start) begin
          en_d  = bank_en;
          cnt_d = '0;
          if (bank_en == '0) begin
            state_d = S_DONE;
          end else begin
            cur_d   = lowest_idx(bank_en);
            state_d = S_SOP;
          end
        end
      end
      S_SOP: state_d = S_XFER;
      S_XFER: begin
        if (fire) begin
          cnt_d = sat_inc(cnt_q);
          if (sel_last) begin
            en_d = en_rest;
            // Visited banks are cleared, so the lowest remaining bit is the next-higher bank.
            if (en_rest == '0) begin
              state_d = S_DONE;
            end else begin
              cur_d   = lowest_idx(en_rest);
              state_d = S_SOP;
            end
          end
        end
      end
      S_DONE: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    // Decode from next state so the pulses are registered yet aligned with SOP/DONE.
    rd_sop_d = (state_d == S_SOP) ? onehot(cur_d) : '0;
    done_d   = (state_d == S_DONE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      en_q     <= '0;
      cur_q    <= '0;
      cnt_q    <= '0;
      rd_sop_q <= '0;
      done_q   <= 1'b0;
      drop_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      en_q     <= en_d;
      cur_q    <= cur_d;
      cnt_q    <= cnt_d;
      rd_sop_q <= rd_sop_d;
      done_q   <= done_d;
      drop_q   <= drop_d;
    end
  end

  assign rd_sop     = rd_sop_q;
  assign done       = done_q;
  assign start_drop = drop_q;
  assign busy       = (state_q != S_IDLE);
  assign word_cnt   = cnt_q;

endmodule

// File: tb/tb_npu_result_drain.sv
// Directed bench for npu_result_drain: a behavioural bank model answers rd_sop
// with a programmed number of words; a negedge monitor logs rd_sop pulses,
// transfers and done pulses for the scenario tasks to compare.
module tb_npu_result_drain;
  localparam int NB = 8;
  localparam int DW = 32;
  localparam int IW = 3;
  localparam int CW = 16;

  logic            clk = 1'b0;
  logic            rst, start;
  logic [NB-1:0]   bank_en, rd_sop, bank_valid, bank_last, bank_ready;
  logic [NB*DW-1:0] bank_data;
  logic            m_valid, m_last, m_ready, busy, done, start_drop;
  logic [DW-1:0]   m_data;
  logic [IW-1:0]   m_bank_id;
  logic [CW-1:0]   word_cnt;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  npu_result_drain #(.NUM_BANK(NB), .DATA_W(DW), .ID_W(IW), .CNT_W(CW)) dut (
    .clk(clk), .rst(rst), .start(start), .bank_en(bank_en), .rd_sop(rd_sop),
    .bank_valid(bank_valid), .bank_data(bank_data), .bank_last(bank_last),
    .bank_ready(bank_ready), .m_valid(m_valid), .m_data(m_data),
    .m_bank_id(m_bank_id), .m_last(m_last), .m_ready(m_ready), .busy(busy),
    .done(done), .start_drop(start_drop), .word_cnt(word_cnt)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [31:0] pat(input int b, input int k);
    return 32'(32'hA500_0000 | (b << 8) | k);
  endfunction

  // Bank model
  int            nwords [NB];
  int            idx    [NB];
  logic [NB-1:0] active;
  logic [NB-1:0] noise = '0;
  logic          bank_clr;

  always @(posedge clk) begin
    for (int i = 0; i < NB; i++) begin
      if (bank_clr) active[i] <= 1'b0;
      else if (rd_sop[i]) begin
        active[i] <= 1'b1;
        idx[i]    <= 0;
      end else if (active[i] && bank_ready[i]) begin
        idx[i] <= idx[i] + 1;
        if (idx[i] + 1 >= nwords[i]) active[i] <= 1'b0;
      end
    end
  end

  always_comb begin
    bank_data = '0;
    for (int i = 0; i < NB; i++) begin
      bank_valid[i] = active[i] | noise[i];
      bank_last[i]  = active[i] ? (idx[i] + 1 == nwords[i]) : noise[i];
      bank_data[i*DW +: DW] = active[i] ? pat(i, idx[i]) : 32'(32'hDEAD_0000 | i);
    end
  end

  // Monitor
  logic [NB-1:0] sop_log [$];
  int            xid     [$];
  logic [DW-1:0] xdata   [$];
  logic          xlast   [$];
  int            done_cnt, done_cyc, last_cyc;
  logic [NB-1:0] rdy_or;

  always @(negedge clk) begin
    if (rd_sop != '0) sop_log.push_back(rd_sop);
    if (m_valid && m_ready) begin
      xid.push_back(int'(m_bank_id));
      xdata.push_back(m_data);
      xlast.push_back(m_last);
      if (m_last) last_cyc = cyc;
    end
    if (done) begin
      done_cnt = done_cnt + 1;
      done_cyc = cyc;
    end
    rdy_or = rdy_or | bank_ready;
  end

  task automatic clear_log();
    sop_log.delete(); xid.delete(); xdata.delete(); xlast.delete();
    done_cnt = 0; done_cyc = -1; last_cyc = -100; rdy_or = '0;
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic pulse_start(input logic [NB-1:0] en);
    start = 1'b1; bank_en = en;
    tick();
    start = 1'b0;
  endtask

  task automatic wait_done(input int limit, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < limit; i++) begin
      @(negedge clk);
      if (done) begin ok = 1'b1; break; end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; bank_en = '0; m_ready = 1'b0; bank_clr = 1'b1;
    repeat (3) tick();
    rst = 1'b0; bank_clr = 1'b0;
    @(negedge clk);
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", busy); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b expected 0", done); end
    checks++; if (rd_sop !== 8'h00) begin errors++; $display("FAIL reset_rd_sop: got %h expected 00", rd_sop); end
    checks++; if (start_drop !== 1'b0) begin errors++; $display("FAIL reset_start_drop: got %b expected 0", start_drop); end
    checks++; if (word_cnt !== 16'd0) begin errors++; $display("FAIL reset_word_cnt: got %0d expected 0", word_cnt); end
    checks++; if ({m_valid, m_last} !== 2'b00) begin errors++; $display("FAIL reset_m_valid_last: got %b expected 00", {m_valid, m_last}); end
    checks++; if (bank_ready !== 8'h00) begin errors++; $display("FAIL reset_bank_ready: got %h expected 00", bank_ready); end
    checks++; if (m_data !== 32'h0) begin errors++; $display("FAIL reset_m_data: got %h expected 0", m_data); end
    tick();
  endtask

  task automatic test_all_banks();
    bit ok;
    for (int i = 0; i < NB; i++) nwords[i] = 3;
    m_ready = 1'b1;
    clear_log();
    pulse_start(8'hFF);
    wait_done(300, ok);
    tick();
    checks++; if (!ok) begin errors++; $display("FAIL all_done_timeout: got no done expected done"); end
    checks++; if (sop_log.size() != 8) begin errors++; $display("FAIL all_sop_count: got %0d expected 8", sop_log.size()); end
    for (int k = 0; k < 8 && k < sop_log.size(); k++) begin
      checks++; if (sop_log[k] !== (8'h01 << k)) begin errors++; $display("FAIL all_sop[%0d]: got %h expected %h", k, sop_log[k], 8'h01 << k); end
    end
    checks++; if (xid.size() != 24) begin errors++; $display("FAIL all_xfer_count: got %0d expected 24", xid.size()); end
    for (int k = 0; k < 24 && k < xid.size(); k++) begin
      checks++; if (xid[k] != k / 3) begin errors++; $display("FAIL all_id[%0d]: got %0d expected %0d", k, xid[k], k / 3); end
      checks++; if (xdata[k] !== pat(k / 3, k % 3)) begin errors++; $display("FAIL all_data[%0d]: got %h expected %h", k, xdata[k], pat(k / 3, k % 3)); end
      checks++; if (xlast[k] !== (k == 23)) begin errors++; $display("FAIL all_last[%0d]: got %b expected %b", k, xlast[k], k == 23); end
    end
    checks++; if (done_cnt != 1) begin errors++; $display("FAIL all_done_cnt: got %0d expected 1", done_cnt); end
    checks++; if (done_cyc != last_cyc + 1) begin errors++; $display("FAIL all_done_timing: got cycle %0d expected %0d", done_cyc, last_cyc + 1); end
    checks++; if (word_cnt !== 16'd24) begin errors++; $display("FAIL all_word_cnt: got %0d expected 24", word_cnt); end
  endtask

  task automatic test_sparse();
    bit ok;
    int exp_id [6] = '{2, 2, 5, 5, 7, 7};
    for (int i = 0; i < NB; i++) nwords[i] = 2;
    m_ready = 1'b1;
    noise = ~8'hA4;
    clear_log();
    pulse_start(8'hA4);
    wait_done(200, ok);
    tick();
    noise = '0;
    checks++; if (!ok) begin errors++; $display("FAIL sparse_done_timeout: got no done expected done"); end
    checks++; if (sop_log.size() != 3) begin errors++; $display("FAIL sparse_sop_count: got %0d expected 3", sop_log.size()); end
    if (sop_log.size() == 3) begin
      checks++; if ({sop_log[0], sop_log[1], sop_log[2]} !== 24'h04_20_80) begin errors++; $display("FAIL sparse_sop_seq: got %h %h %h expected 04 20 80", sop_log[0], sop_log[1], sop_log[2]); end
    end
    checks++; if ((rdy_or & ~8'hA4) !== 8'h00) begin errors++; $display("FAIL sparse_ready_other: got %h expected 00", rdy_or & ~8'hA4); end
    checks++; if (xid.size() != 6) begin errors++; $display("FAIL sparse_xfer_count: got %0d expected 6", xid.size()); end
    for (int k = 0; k < 6 && k < xid.size(); k++) begin
      checks++; if (xdata[k] !== pat(exp_id[k], k % 2)) begin errors++; $display("FAIL sparse_data[%0d]: got %h expected %h", k, xdata[k], pat(exp_id[k], k % 2)); end
    end
    checks++; if (word_cnt !== 16'd6) begin errors++; $display("FAIL sparse_word_cnt: got %0d expected 6", word_cnt); end
  endtask

  task automatic test_empty();
    m_ready = 1'b1;
    clear_log();
    start = 1'b1; bank_en = 8'h00;
    @(negedge clk);
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL empty_busy_pre: got %b expected 0", busy); end
    tick();
    start = 1'b0;
    @(negedge clk);
    checks++; if ({busy, done} !== 2'b11) begin errors++; $display("FAIL empty_busy_done: got %b expected 11", {busy, done}); end
    @(negedge clk);
    checks++; if ({busy, done} !== 2'b00) begin errors++; $display("FAIL empty_idle_after: got %b expected 00", {busy, done}); end
    checks++; if (sop_log.size() != 0 || xid.size() != 0) begin errors++; $display("FAIL empty_activity: got %0d sop %0d xfer expected 0 0", sop_log.size(), xid.size()); end
    checks++; if (word_cnt !== 16'd0) begin errors++; $display("FAIL empty_word_cnt: got %0d expected 0", word_cnt); end
    tick();
  endtask

  task automatic test_backpressure();
    int hs = 0;
    bit seen = 1'b0, prev_stall = 1'b0;
    logic [DW-1:0] prev_data = '0;
    nwords[0] = 4;
    m_ready = 1'b0;
    clear_log();
    pulse_start(8'h01);
    for (int i = 0; i < 60; i++) begin
      m_ready = ~m_ready;
      @(negedge clk);
      if (m_valid) begin
        checks++; if (bank_ready !== (m_ready ? 8'h01 : 8'h00)) begin errors++; $display("FAIL bp_ready: got %h expected %h", bank_ready, m_ready ? 8'h01 : 8'h00); end
        if (prev_stall) begin
          checks++; if (m_data !== prev_data) begin errors++; $display("FAIL bp_data_stable: got %h expected %h", m_data, prev_data); end
        end
        checks++; if (word_cnt !== 16'(hs)) begin errors++; $display("FAIL bp_word_cnt: got %0d expected %0d", word_cnt, hs); end
        if (m_ready) hs++;
        prev_stall = !m_ready;
        prev_data = m_data;
      end else prev_stall = 1'b0;
      if (done) begin seen = 1'b1; break; end
      tick();
    end
    tick();
    m_ready = 1'b1;
    checks++; if (!seen) begin errors++; $display("FAIL bp_done_timeout: got no done expected done"); end
    checks++; if (hs != 4) begin errors++; $display("FAIL bp_handshakes: got %0d expected 4", hs); end
    checks++; if (word_cnt !== 16'd4) begin errors++; $display("FAIL bp_word_cnt_final: got %0d expected 4", word_cnt); end
    for (int k = 0; k < 4 && k < xdata.size(); k++) begin
      checks++; if (xdata[k] !== pat(0, k)) begin errors++; $display("FAIL bp_data[%0d]: got %h expected %h", k, xdata[k], pat(0, k)); end
    end
  endtask

  task automatic test_drop_restart();
    bit ok, got_v = 1'b0;
    nwords[0] = 3; nwords[1] = 3; nwords[4] = 1;
    m_ready = 1'b1;
    clear_log();
    pulse_start(8'h03);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (m_valid) begin got_v = 1'b1; break; end
    end
    checks++; if (!got_v) begin errors++; $display("FAIL drop_xfer_timeout: got no m_valid expected m_valid"); end
    tick();
    start = 1'b1; bank_en = 8'hFF;
    @(negedge clk);
    checks++; if (start_drop !== 1'b0) begin errors++; $display("FAIL drop_early: got %b expected 0", start_drop); end
    tick();
    start = 1'b0;
    @(negedge clk);
    checks++; if (start_drop !== 1'b1) begin errors++; $display("FAIL drop_pulse: got %b expected 1", start_drop); end
    tick();
    @(negedge clk);
    checks++; if (start_drop !== 1'b0) begin errors++; $display("FAIL drop_one_cycle: got %b expected 0", start_drop); end
    tick();
    wait_done(100, ok);
    tick();
    checks++; if (!ok) begin errors++; $display("FAIL drop_done_timeout: got no done expected done"); end
    checks++; if (sop_log.size() != 2) begin errors++; $display("FAIL drop_sop_count: got %0d expected 2", sop_log.size()); end
    checks++; if (word_cnt !== 16'd6) begin errors++; $display("FAIL drop_word_cnt: got %0d expected 6", word_cnt); end
    // Fresh start in the IDLE cycle right after DONE.
    clear_log();
    start = 1'b1; bank_en = 8'h10;
    tick();
    start = 1'b0;
    @(negedge clk);
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL restart_busy: got %b expected 1", busy); end
    checks++; if (rd_sop !== 8'h10) begin errors++; $display("FAIL restart_rd_sop: got %h expected 10", rd_sop); end
    checks++; if (word_cnt !== 16'd0) begin errors++; $display("FAIL restart_cnt_clear: got %0d expected 0", word_cnt); end
    tick();
    wait_done(50, ok);
    tick();
    checks++; if (!ok) begin errors++; $display("FAIL restart_done_timeout: got no done expected done"); end
    checks++; if (word_cnt !== 16'd1) begin errors++; $display("FAIL restart_word_cnt: got %0d expected 1", word_cnt); end
  endtask

  task automatic test_reset_mid();
    bit got_v = 1'b0;
    nwords[3] = 10;
    m_ready = 1'b1;
    clear_log();
    pulse_start(8'h08);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (m_valid && m_bank_id == 3'd3) begin got_v = 1'b1; break; end
    end
    checks++; if (!got_v) begin errors++; $display("FAIL rmid_xfer_timeout: got no bank3 word expected bank3 word"); end
    tick(); tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    @(negedge clk);
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rmid_busy: got %b expected 0", busy); end
    checks++; if (rd_sop !== 8'h00) begin errors++; $display("FAIL rmid_rd_sop: got %h expected 00", rd_sop); end
    checks++; if (bank_ready !== 8'h00) begin errors++; $display("FAIL rmid_bank_ready: got %h expected 00", bank_ready); end
    checks++; if (word_cnt !== 16'd0) begin errors++; $display("FAIL rmid_word_cnt: got %0d expected 0", word_cnt); end
    checks++; if (m_valid !== 1'b0) begin errors++; $display("FAIL rmid_m_valid: got %b expected 0", m_valid); end
    tick();
    repeat (20) tick();
    checks++; if (done_cnt != 0) begin errors++; $display("FAIL rmid_no_done: got %0d done pulses expected 0", done_cnt); end
    bank_clr = 1'b1;
    tick();
    bank_clr = 1'b0;
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; bank_en = '0; m_ready = 1'b0; bank_clr = 1'b1;
    for (int i = 0; i < NB; i++) nwords[i] = 1;
    clear_log();
    test_reset();
    test_all_banks();
    test_sparse();
    test_empty();
    test_backpressure();
    test_drop_restart();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/npu_result_drain.md
Name: npu_result_drain

Overview:
- Sequences readback of the NUM_BANK PE result-cache banks onto a single shared output stream after the NPU controller's save phase.
- On a start pulse it visits each enabled bank in ascending index order: it issues a one-cycle read-start pulse to the bank, then forwards that bank's words until the bank flags its last word.
- Reports completion with a done pulse and a word count.
- Sits between the pe_result_cache banks and the NPU-to-AXI write-back path.

Parameters:
- NUM_BANK, 8, number of result-cache banks.
- DATA_W, 32, width of one result word.
- ID_W, 3, width of the bank index; must satisfy 2^ID_W >= NUM_BANK.
- CNT_W, 16, width of the per-job word counter.

Ports:
- clk  in  1  clock; all logic is on the rising edge.
- rst  in  1  synchronous active-high reset.
- start  in  1  one-cycle job start pulse (driven by the controller's save_sop).
- bank_en  in  NUM_BANK  banks to drain; sampled only on an accepted start.
- rd_sop  out  NUM_BANK  per-bank one-cycle read-start pulse.
- bank_valid  in  NUM_BANK  per-bank word valid.
- bank_data  in  NUM_BANK*DATA_W  bank i occupies bits [i*DATA_W +: DATA_W].
- bank_last  in  NUM_BANK  per-bank last-word flag (rd_eop), qualified by bank_valid.
- bank_ready  out  NUM_BANK  per-bank pop strobe.
- m_valid  out  1  output word valid.
- m_data  out  DATA_W  output word.
- m_bank_id  out  ID_W  index of the bank currently being forwarded.
- m_last  out  1  last word of the job.
- m_ready  in  1  downstream accept.
- busy  out  1  high whenever the FSM is not in IDLE.
- done  out  1  one-cycle job-complete pulse.
- start_drop  out  1  one-cycle pulse when a start arrives while busy.
- word_cnt  out  CNT_W  words transferred in the current or last job.

Behaviour:
- Reset (rst=1 at a clock edge):
  - FSM goes to IDLE.
  - en_q=0, cur=0, word_cnt=0.
  - rd_sop=0, done=0, start_drop=0, busy=0.
  - The combinational outputs m_valid and bank_ready are 0 in IDLE.
  - Reset mid-job abandons the job with no done pulse; banks are not notified.
- States: IDLE, SOP, XFER, DONE.
- IDLE:
  - On start=1: latch en_q<=bank_en and clear word_cnt to 0.
  - If bank_en==0, go to DONE.
  - Otherwise cur<=lowest set index of bank_en and go to SOP.
- SOP (exactly 1 cycle):
  - rd_sop is registered and equals onehot(cur) only while in SOP; all other bits are 0.
  - Next state is XFER.
- XFER (combinational forwarding, zero latency):
  - m_valid=bank_valid[cur], m_data=bank data slice cur, m_bank_id=cur.
  - bank_ready=onehot(cur) & {NUM_BANK{m_ready}}.
  - Non-selected banks get bank_ready=0; their valid, data and last inputs are ignored.
  - Transfer = m_valid & m_ready. Each transfer increments word_cnt, saturating at all-ones.
  - Transfer with bank_last[cur]=1:
    - clear en_q[cur];
    - if no other en_q bit is set, go to DONE;
    - else cur<=next-higher set index and go to SOP.
  - m_last = bank_valid[cur] & bank_last[cur] & (en_q has no bit set other than cur).
  - bank_last is ignored when bank_valid is low.
  - No timeout: XFER waits indefinitely for valid and ready.
- DONE (exactly 1 cycle):
  - done=1 (registered, high only in DONE); next state is IDLE.
  - word_cnt holds its value until the next accepted start.
- Outside XFER: m_valid=0, bank_ready=0, m_last=0, m_data=0, m_bank_id=cur.
- Start handling:
  - start while busy (any state other than IDLE) is ignored and start_drop pulses 1 cycle later.
  - start in the IDLE cycle that immediately follows DONE is accepted normally.
- Ordering and gaps:
  - Banks are always drained in ascending index order; disabled banks are skipped without an rd_sop.
  - The minimum gap between banks is one SOP cycle with m_valid=0.
  - A single-word bank (first word has last=1) moves straight to the next SOP.

Test Plan:
- Reset, then start with bank_en=8'hFF; each bank supplies 3 words with m_ready=1:
  - rd_sop pulses 0x01, 0x02 … 0x80 in order;
  - 24 transfers with m_bank_id 0..7;
  - m_last is high only on bank 7's third word;
  - done pulses one cycle after that transfer; word_cnt=24.
- bank_en=8'b1010_0100, 2 words per bank:
  - rd_sop pulses only 0x04, 0x20, 0x80;
  - bank_ready is never asserted for other banks; word_cnt=6.
- bank_en=0 start:
  - busy for 1 cycle, done pulses on the cycle after start;
  - no rd_sop, no m_valid; word_cnt=0.
- Backpressure: toggle m_ready 1/0 every cycle with bank 0 holding 4 words:
  - bank_ready[0] mirrors m_ready;
  - m_data stays stable while m_valid=1 and m_ready=0;
  - word_cnt increments only on handshake cycles.
- Second start pulse while in XFER:
  - start_drop pulses one cycle later; the job completes unchanged;
  - a fresh start in the IDLE cycle after done is accepted and word_cnt restarts from 0.
- Assert rst=1 for 1 cycle mid-XFER on bank 3:
  - next cycle busy=0, rd_sop=0, bank_ready=0, word_cnt=0;
  - no done pulse is ever produced for the abandoned job.
